// File: rtl/dh_cc_responder.sv
// dh_cc_responder: control-centre side of the drone Diffie-Hellman exchange.
// Takes one {id, A} request, computes pub = G^SECRET mod P and
// key = A^SECRET mod P by MSB-first square-and-multiply (one exponent bit
// per enabled cycle), then returns pub with a one-cycle mess_rdy/key_rdy.
module dh_cc_responder #(
    parameter int             N      = 8,
    parameter int             P1     = 137,
    parameter int             G1     = 5,
    parameter int             P2     = 229,
    parameter int             G2     = 2,
    parameter logic [N-1:0]   SECRET = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             drone_rdy,
    input  logic [2*N-1:0]   mess_input,
    output logic [N-1:0]     mess_out,
    output logic             mess_rdy,
    output logic [N-1:0]     key,
    output logic [N-1:0]     key_id,
    output logic             key_rdy,
    output logic             busy,
    output logic             err
);

    localparam int           IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
    localparam logic [N-1:0] P1_V    = P1[N-1:0];
    localparam logic [N-1:0] G1_V    = G1[N-1:0];
    localparam logic [N-1:0] P2_V    = P2[N-1:0];
    localparam logic [N-1:0] G2_V    = G2[N-1:0];
    localparam logic [N-1:0] ONE     = N'(1);
    localparam logic [N-1:0] DRONE1  = N'(1);
    localparam logic [N-1:0] DRONE2  = N'(2);

    typedef struct packed {
        logic [N-1:0] id;
        logic [N-1:0] a;
    } req_t;

    typedef enum logic [2:0] {IDLE, EXP_PUB, EXP_KEY, REPLY, ERROR} state_t;

    state_t         state, state_nxt;
    req_t           req;
    logic [N-1:0]   id_q, a_q, p_q, g_q, acc, pub;
    logic [IW-1:0]  idx;

    logic [N-1:0]   sel_p, sel_g;
    logic           req_ok;
    logic [N-1:0]   base, sq, step;
    logic [2*N-1:0] p_ext, sq_prod, mul_prod;

    assign req = mess_input;

    // Decode the incoming request: pick the drone's (P, G) and validate A.
    always_comb begin
        sel_p  = ONE;
        sel_g  = ONE;
        req_ok = 1'b0;
        case (req.id)
            DRONE1: begin sel_p = P1_V; sel_g = G1_V; req_ok = 1'b1; end
            DRONE2: begin sel_p = P2_V; sel_g = G2_V; req_ok = 1'b1; end
            default: ;
        endcase
        if (req.a == '0 || req.a >= sel_p)
            req_ok = 1'b0;
    end

    // One square-and-multiply step; p_q never holds 0 (reset loads 1).
    always_comb begin
        p_ext    = {{N{1'b0}}, p_q};
        base     = (state == EXP_KEY) ? a_q : g_q;
        sq_prod  = {{N{1'b0}}, acc} * {{N{1'b0}}, acc};
        sq       = N'(sq_prod % p_ext);
        mul_prod = {{N{1'b0}}, sq} * {{N{1'b0}}, base};
        step     = SECRET[idx] ? N'(mul_prod % p_ext) : sq;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drone_rdy) state_nxt = req_ok ? EXP_PUB : ERROR;
            EXP_PUB: if (idx == '0) state_nxt = EXP_KEY;
            EXP_KEY: if (idx == '0) state_nxt = REPLY;
            REPLY:   state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, datapath and registered outputs; pulses are issued
    // on the edge that leaves REPLY / ERROR, so they land in the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            id_q     <= '0;
            a_q      <= '0;
            p_q      <= ONE;
            g_q      <= ONE;
            acc      <= ONE;
            idx      <= IDX_TOP;
            pub      <= '0;
            mess_out <= '0;
            mess_rdy <= 1'b0;
            key      <= '0;
            key_id   <= '0;
            key_rdy  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else if (ena) begin
            state    <= state_nxt;
            mess_rdy <= (state == REPLY);
            key_rdy  <= (state == REPLY);
            err      <= (state == ERROR);
            case (state)
                IDLE: begin
                    if (drone_rdy) begin
                        id_q <= req.id;
                        a_q  <= req.a;
                        if (req_ok) begin
                            p_q  <= sel_p;
                            g_q  <= sel_g;
                            acc  <= ONE;
                            idx  <= IDX_TOP;
                            busy <= 1'b1;
                        end
                    end
                end
                EXP_PUB: begin
                    if (idx == '0) begin
                        pub <= step;
                        acc <= ONE;
                        idx <= IDX_TOP;
                    end else begin
                        acc <= step;
                        idx <= idx - 1'b1;
                    end
                end
                EXP_KEY: begin
                    if (idx == '0) begin
                        key      <= step;
                        key_id   <= id_q;
                        mess_out <= pub;
                        acc      <= ONE;
                        idx      <= IDX_TOP;
                    end else begin
                        acc <= step;
                        idx <= idx - 1'b1;
                    end
                end
                REPLY:   busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_cc_responder.sv
// Directed bench for dh_cc_responder (N=8, P1=137/G1=5, P2=229/G2=2, SECRET=3).
module tb_dh_cc_responder;

    logic        clk = 1'b0;
    logic        rst, ena, drone_rdy;
    logic [15:0] mess_input;
    logic [7:0]  mess_out, key, key_id;
    logic        mess_rdy, key_rdy, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    dh_cc_responder dut (
        .clk(clk), .rst(rst), .ena(ena), .drone_rdy(drone_rdy),
        .mess_input(mess_input), .mess_out(mess_out), .mess_rdy(mess_rdy),
        .key(key), .key_id(key_id), .key_rdy(key_rdy), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full exchange: capture, wait for the reply, check results.
    task automatic run_xchg(input logic [7:0] id, input logic [7:0] a, input bit tog,
                            input bit inj, input logic [7:0] e_pub,
                            input logic [7:0] e_key, input string tag);
        int  n, cyc, errs, extra;
        bit  en_now;
        mess_input = {id, a};
        drone_rdy  = 1'b1;
        ena        = 1'b1;
        tick;
        drone_rdy = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 0; cyc = 0; errs = 0;
        while (!mess_rdy && cyc < 100) begin
            ena       = tog ? ~ena : 1'b1;
            drone_rdy = inj && (n == 5);
            if (inj && n == 5) mess_input = 16'h010A;
            en_now = ena;
            tick;
            cyc++;
            if (en_now) n++;
            errs += int'(err);
        end
        ena       = 1'b1;
        drone_rdy = 1'b0;
        chk({tag, "_lat"},     n,        17);
        chk({tag, "_rdy"},     mess_rdy, 1);
        chk({tag, "_keyrdy"},  key_rdy,  1);
        chk({tag, "_pub"},     mess_out, e_pub);
        chk({tag, "_key"},     key,      e_key);
        chk({tag, "_keyid"},   key_id,   id);
        chk({tag, "_noerr"},   errs,     0);
        tick;
        chk({tag, "_rdy_off"}, mess_rdy, 0);
        chk({tag, "_kr_off"},  key_rdy,  0);
        chk({tag, "_idle"},    busy,     0);
        extra = 0;
        repeat (4) begin
            tick;
            extra += int'(mess_rdy) + int'(err);
        end
        chk({tag, "_quiet"}, extra, 0);
    endtask

    // Rejected request: err one cycle after capture, outputs untouched.
    task automatic err_req(input logic [7:0] id, input logic [7:0] a, input string tag);
        mess_input = {id, a};
        drone_rdy  = 1'b1;
        tick;
        drone_rdy = 1'b0;
        chk({tag, "_err0"}, err,  0);
        chk({tag, "_busy"}, busy, 0);
        tick;
        chk({tag, "_err1"}, err,      1);
        chk({tag, "_rdy"},  mess_rdy, 0);
        tick;
        chk({tag, "_err2"}, err,      0);
        chk({tag, "_key"},  key,      186);
        chk({tag, "_kid"},  key_id,   2);
        chk({tag, "_pub"},  mess_out, 8);
    endtask

    initial begin
        int stale;
        rst = 1'b0; ena = 1'b1; drone_rdy = 1'b1; mess_input = 16'h010A;
        repeat (3) tick;
        chk("rst_pub",  mess_out, 0);
        chk("rst_rdy",  mess_rdy, 0);
        chk("rst_key",  key,      0);
        chk("rst_kid",  key_id,   0);
        chk("rst_krdy", key_rdy,  0);
        chk("rst_busy", busy,     0);
        chk("rst_err",  err,      0);

        rst = 1'b1;
        run_xchg(8'd1, 8'd10,  1'b0, 1'b0, 8'd125, 8'd41,  "d1");
        run_xchg(8'd2, 8'd100, 1'b0, 1'b1, 8'd8,   8'd186, "d2");

        err_req(8'd3, 8'd10,  "bad_id");
        err_req(8'd1, 8'd0,   "a_zero");
        err_req(8'd1, 8'd137, "a_eq_p");

        run_xchg(8'd1, 8'd10, 1'b1, 1'b0, 8'd125, 8'd41, "d1_ena");

        // Abort mid EXP_KEY with reset; no stale reply may follow.
        mess_input = 16'h010A;
        drone_rdy  = 1'b1;
        tick;
        drone_rdy = 1'b0;
        repeat (10) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("abort_busy", busy,     0);
        chk("abort_rdy",  mess_rdy, 0);
        chk("abort_key",  key,      0);
        stale = 0;
        repeat (20) begin
            tick;
            stale += int'(mess_rdy);
        end
        chk("abort_stale", stale, 0);
        run_xchg(8'd1, 8'd10, 1'b0, 1'b0, 8'd125, 8'd41, "d1_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
